prio_rr_arbiter: RTL

Shares one service resource (DMA port, bus master slot) among NUM_REQ requesters.
Each requester has a priority register, programmable over the same APB-style processor interface used by the interrupt controller. The winner is the highest-priority eligible request; ties are broken round-robin. A grant is held until the resource reports completion, with an optional watchdog release.

---
 rtl/prio_rr_arbiter_pkg.sv | 15 +
 rtl/prio_rr_arbiter_if.sv | 32 +++
 rtl/prio_rr_arbiter_pick.sv | 48 ++++
 rtl/prio_rr_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_rr_arbiter_pkg.sv
// Shared types and constants for the priority/round-robin arbiter.
// State encoding is one-hot; register addresses cover the non-priority registers.
package prio_rr_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ARB   = 3'b010,
        S_GRANT = 3'b100
    } arb_state_t;

    localparam logic [7:0] ADDR_MASK    = 8'h10;
    localparam logic [7:0] ADDR_STATUS  = 8'h11;
    localparam logic [7:0] ADDR_TIMEOUT = 8'h12;

endpackage

// File: rtl/prio_rr_arbiter_if.sv
// Processor-bus and request/grant bundle for prio_rr_arbiter.
// The master side drives accesses and requests; the slave side is the arbiter.
interface prio_rr_arbiter_if #(
    parameter int NUM_REQ = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [7:0]         paddr_i;
    logic [7:0]         pwdata_i;
    logic               pwrite_i;
    logic               penable_i;
    logic [7:0]         prdata_o;
    logic               pready_o;
    logic               perror_o;
    logic [NUM_REQ-1:0] req_i;
    logic               done_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [IDW-1:0]     gnt_id_o;
    logic               gnt_valid_o;
    logic               timeout_o;

    modport master (
        output paddr_i, pwdata_i, pwrite_i, penable_i, req_i, done_i,
        input  prdata_o, pready_o, perror_o, gnt_o, gnt_id_o, gnt_valid_o, timeout_o
    );

    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, penable_i, req_i, done_i,
        output prdata_o, pready_o, perror_o, gnt_o, gnt_id_o, gnt_valid_o, timeout_o
    );

endinterface

// File: rtl/prio_rr_arbiter_pick.sv
// Combinational winner selection: highest priority among eligible requests,
// ties resolved by the first index found scanning upward from the round-robin pointer.
module prio_rr_pick #(
    parameter int NUM_REQ = 8,
    parameter int PRIO_W  = 3,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]        i_elig,
    input  logic [NUM_REQ*PRIO_W-1:0] i_prio_flat,
    input  logic [IDW-1:0]            i_rr_ptr,
    output logic [IDW-1:0]            o_win_id,
    output logic                      o_any_valid
);
    localparam int SW = IDW + 1;

    logic [SW-1:0]     w_sum;
    logic [IDW-1:0]    w_idx;
    logic [IDW-1:0]    w_best_id;
    logic [PRIO_W-1:0] w_best;
    logic [PRIO_W-1:0] w_cur;
    logic              w_found;

    // Strict '>' keeps the earliest index in scan order among equal maxima.
    always_comb begin
        w_sum     = '0;
        w_idx     = '0;
        w_cur     = '0;
        w_best    = '0;
        w_best_id = '0;
        w_found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_rr_ptr} + SW'(k);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            w_idx = w_sum[IDW-1:0];
            w_cur = i_prio_flat[w_idx*PRIO_W +: PRIO_W];
            if (i_elig[w_idx] && (!w_found || (w_cur > w_best))) begin
                w_found   = 1'b1;
                w_best    = w_cur;
                w_best_id = w_idx;
            end
        end
        o_win_id    = w_best_id;
        o_any_valid = w_found;
    end

endmodule

// File: rtl/prio_rr_arbiter.sv
// Priority arbiter with round-robin tie-break, sticky grants and a register file.
// Optional grant watchdog enabled by defining PRIO_RR_ARB_TIMEOUT_EN.
module prio_rr_arbiter
    import prio_rr_arb_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int PRIO_W  = 3,
    parameter int TO_W    = 8
) (
    input  logic             pclk_i,
    input  logic             prst_i,
    prio_rr_arbiter_if.slave bus
);
    localparam int         IDW          = $clog2(NUM_REQ);
    localparam logic [7:0] PRIO_ADDR_HI = 8'(NUM_REQ);

    logic [PRIO_W-1:0]         r_prio [NUM_REQ];
    logic [NUM_REQ-1:0]        r_mask;
    logic [7:0]                r_prdata;
    logic                      r_pready;
    logic                      r_perror;

    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic [NUM_REQ-1:0]        r_gnt;
    logic [NUM_REQ-1:0]        w_gnt_nxt;
    logic [IDW-1:0]            r_gnt_id;
    logic [IDW-1:0]            w_gnt_id_nxt;
    logic                      r_gnt_valid;
    logic                      w_gnt_valid_nxt;
    logic [IDW-1:0]            r_rr_ptr;
    logic [IDW-1:0]            w_rr_ptr_nxt;
    logic [IDW-1:0]            r_last_id;
    logic [IDW-1:0]            w_last_id_nxt;

    logic [NUM_REQ*PRIO_W-1:0] w_prio_flat;
    logic [NUM_REQ-1:0]        w_elig;
    logic [IDW-1:0]            w_win;
    logic                      w_any;
    logic                      w_addr_prio;
    logic                      w_addr_ok;
    logic [7:0]                w_rdata;
    logic                      w_to_hit;
    logic                      w_release;
    logic [TO_W-1:0]           w_limit_rd;

`ifdef PRIO_RR_ARB_TIMEOUT_EN
    logic [TO_W-1:0]           r_limit;
    logic [TO_W-1:0]           r_to_cnt;
    logic                      r_timeout;
`endif

    assign w_elig = bus.req_i & r_mask;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_flat
        assign w_prio_flat[g*PRIO_W +: PRIO_W] = r_prio[g];
    end

    prio_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PRIO_W  (PRIO_W)
    ) u_pick (
        .i_elig      (w_elig),
        .i_prio_flat (w_prio_flat),
        .i_rr_ptr    (r_rr_ptr),
        .o_win_id    (w_win),
        .o_any_valid (w_any)
    );

    // Register decode and read mux.
    always_comb begin
        w_addr_prio = (bus.paddr_i < PRIO_ADDR_HI);
        w_addr_ok   = w_addr_prio || (bus.paddr_i == ADDR_MASK) ||
                      (bus.paddr_i == ADDR_STATUS) || (bus.paddr_i == ADDR_TIMEOUT);
        w_rdata     = '0;
        if (w_addr_prio) begin
            w_rdata = 8'(r_prio[bus.paddr_i[IDW-1:0]]);
        end else begin
            case (bus.paddr_i)
                ADDR_MASK:    w_rdata = 8'(r_mask);
                ADDR_STATUS:  w_rdata = {r_gnt_valid, 7'(r_last_id)};
                ADDR_TIMEOUT: w_rdata = 8'(w_limit_rd);
                default:      w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_prio[i] <= '0;
            end
            r_mask   <= '1;
            r_prdata <= '0;
            r_pready <= 1'b0;
            r_perror <= 1'b0;
`ifdef PRIO_RR_ARB_TIMEOUT_EN
            r_limit  <= '1;
`endif
        end else begin
            r_pready <= bus.penable_i;
            r_perror <= bus.penable_i && !w_addr_ok;
            r_prdata <= (bus.penable_i && !bus.pwrite_i && w_addr_ok) ? w_rdata : 8'h00;
            if (bus.penable_i && bus.pwrite_i && w_addr_ok) begin
                if (w_addr_prio) begin
                    r_prio[bus.paddr_i[IDW-1:0]] <= PRIO_W'(bus.pwdata_i);
                end
                if (bus.paddr_i == ADDR_MASK) begin
                    r_mask <= NUM_REQ'(bus.pwdata_i);
                end
`ifdef PRIO_RR_ARB_TIMEOUT_EN
                if (bus.paddr_i == ADDR_TIMEOUT) begin
                    r_limit <= TO_W'(bus.pwdata_i);
                end
`endif
            end
        end
    end

`ifdef PRIO_RR_ARB_TIMEOUT_EN
    // done_i has precedence over the watchdog on the same cycle.
    assign w_to_hit   = (r_state == S_GRANT) && !bus.done_i && (r_to_cnt == r_limit);
    assign w_limit_rd = r_limit;

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if (r_state == S_ARB) begin
                r_to_cnt <= '0;
            end else if (r_state == S_GRANT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout_o = r_timeout;
`else
    assign w_to_hit      = 1'b0;
    assign w_limit_rd    = '0;
    assign bus.timeout_o = 1'b0;
`endif

    assign w_release = bus.done_i || w_to_hit;

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_rr_ptr    <= '0;
            r_last_id   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_last_id   <= w_last_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_last_id_nxt   = r_last_id;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                // Requests may have vanished since IDLE saw them.
                if (w_any) begin
                    w_gnt_nxt       = NUM_REQ'(1) << w_win;
                    w_gnt_id_nxt    = w_win;
                    w_gnt_valid_nxt = 1'b1;
                    w_last_id_nxt   = w_win;
                    w_rr_ptr_nxt    = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                    w_state_nxt     = S_GRANT;
                end else begin
                    w_state_nxt     = S_IDLE;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_gnt_nxt       = '0;
                    w_gnt_id_nxt    = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_state_nxt     = (|w_elig) ? S_ARB : S_IDLE;
                end
            end
            default: begin
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
        endcase
    end

    assign bus.prdata_o    = r_prdata;
    assign bus.pready_o    = r_pready;
    assign bus.perror_o    = r_perror;
    assign bus.gnt_o       = r_gnt;
    assign bus.gnt_id_o    = r_gnt_id;
    assign bus.gnt_valid_o = r_gnt_valid;

endmodule
